// File: rtl/pc_stack_unit.sv
// Program counter register plus circular call/return address stack for the 12-bit sequencer.
// Optional interrupt-entry support (flag shadow + push of current PC) is enabled by defining PC_STACK_INT_EN.
module pc_stack_unit #(
  parameter int                ADDR_W       = 12,
  parameter int                DEPTH        = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 12'h000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [ADDR_W-1:0]          next_pc_i,
  input  logic                       push_i,
  input  logic                       pop_i,
`ifdef PC_STACK_INT_EN
  input  logic                       int_ack_i,
  input  logic                       zero_i,
  input  logic                       carry_i,
  output logic                       zero_o,
  output logic                       carry_o,
`endif
  output logic [ADDR_W-1:0]          pc_o,
  output logic [ADDR_W-1:0]          stk_o,
  output logic [$clog2(DEPTH):0]     depth_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       ovf_o,
  output logic                       unf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];

  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] wr_data;
  logic [ADDR_W-1:0] ret_addr;
  logic              do_push;
  logic              do_pop;
  logic              is_empty;
  logic              is_full;

`ifdef PC_STACK_INT_EN
  logic zero_q, zero_d;
  logic carry_q, carry_d;
`endif

  assign ret_addr = pc_q + ADDR_W'(1);
  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_W'(DEPTH));

  always_comb begin
    pc_d    = en_i ? next_pc_i : pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_ptr  = top_q + 1'b1;
    wr_data = ret_addr;
    do_push = en_i & push_i;
    do_pop  = en_i & pop_i;
`ifdef PC_STACK_INT_EN
    zero_d  = zero_q;
    carry_d = carry_q;
    // Interrupt entry saves the interrupted PC itself and wins over CALL/RET.
    if (en_i && int_ack_i) begin
      do_push = 1'b1;
      do_pop  = 1'b0;
      wr_data = pc_q;
      zero_d  = zero_i;
      carry_d = carry_i;
    end
`endif

    case ({do_push, do_pop})
      2'b10: begin
        wr_en = 1'b1;
        top_d = top_q + 1'b1;
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      2'b01: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          top_d = top_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        // A RET+CALL pair on an empty stack still records the call.
        if (is_empty) begin
          top_d = top_q + 1'b1;
          cnt_d = CNT_W'(1);
          unf_d = 1'b1;
        end else begin
          wr_ptr = top_q;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

`ifdef PC_STACK_INT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero_o  = zero_q;
  assign carry_o = carry_q;
`endif

  assign pc_o    = pc_q;
  assign stk_o   = is_empty ? RESET_VECTOR : mem_q[top_q];
  assign depth_o = cnt_q;
  assign empty_o = is_empty;
  assign full_o  = is_full;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit (DEPTH=16, RESET_VECTOR=0).
module tb_pc_stack_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [11:0] next_pc_i;
  logic        push_i;
  logic        pop_i;
  logic [11:0] pc_o;
  logic [11:0] stk_o;
  logic [4:0]  depth_o;
  logic        empty_o;
  logic        full_o;
  logic        ovf_o;
  logic        unf_o;
`ifdef PC_STACK_INT_EN
  logic        int_ack_i;
  logic        zero_i;
  logic        carry_i;
  logic        zero_o;
  logic        carry_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  pc_stack_unit #(.ADDR_W(12), .DEPTH(16), .RESET_VECTOR(12'h000)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .next_pc_i (next_pc_i),
    .push_i    (push_i),
    .pop_i     (pop_i),
`ifdef PC_STACK_INT_EN
    .int_ack_i (int_ack_i),
    .zero_i    (zero_i),
    .carry_i   (carry_i),
    .zero_o    (zero_o),
    .carry_o   (carry_o),
`endif
    .pc_o      (pc_o),
    .stk_o     (stk_o),
    .depth_o   (depth_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .ovf_o     (ovf_o),
    .unf_o     (unf_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b1; push_i = 1'b1; pop_i = 1'b0; next_pc_i = 12'h555;
    step();
    step();
    total_cnt++; if (pc_o !== 12'h000) $display("[TB] FAIL reset_pc: got %h want 000", pc_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd0) $display("[TB] FAIL reset_depth: got %0d want 0", depth_o); else pass_cnt++;
    total_cnt++; if (empty_o !== 1'b1) $display("[TB] FAIL reset_empty: got %b want 1", empty_o); else pass_cnt++;
    total_cnt++; if (stk_o !== 12'h000) $display("[TB] FAIL reset_stk: got %h want 000", stk_o); else pass_cnt++;
    total_cnt++; if ({ovf_o, unf_o} !== 2'b00) $display("[TB] FAIL reset_flags: got %b want 00", {ovf_o, unf_o}); else pass_cnt++;
    rst_i = 1'b0; push_i = 1'b0;
  endtask

  task automatic test_pc_load_stall();
    en_i = 1'b1; next_pc_i = 12'h010;
    step();
    total_cnt++; if (pc_o !== 12'h010) $display("[TB] FAIL pc_load: got %h want 010", pc_o); else pass_cnt++;
    en_i = 1'b0; next_pc_i = 12'h020; push_i = 1'b1;
    step();
    total_cnt++; if (pc_o !== 12'h010) $display("[TB] FAIL pc_stall: got %h want 010", pc_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd0) $display("[TB] FAIL stall_depth: got %0d want 0", depth_o); else pass_cnt++;
    en_i = 1'b1; push_i = 1'b0;
  endtask

  task automatic test_call_return();
    next_pc_i = 12'h0FF;
    step();
    push_i = 1'b1; next_pc_i = 12'h200;
    step();
    total_cnt++; if (stk_o !== 12'h100) $display("[TB] FAIL call_stk: got %h want 100", stk_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd1) $display("[TB] FAIL call_depth: got %0d want 1", depth_o); else pass_cnt++;
    total_cnt++; if (pc_o !== 12'h200) $display("[TB] FAIL call_pc: got %h want 200", pc_o); else pass_cnt++;
    push_i = 1'b0; pop_i = 1'b1; next_pc_i = 12'h100;
    #1;
    total_cnt++; if (stk_o !== 12'h100) $display("[TB] FAIL ret_target: got %h want 100", stk_o); else pass_cnt++;
    step();
    total_cnt++; if (empty_o !== 1'b1) $display("[TB] FAIL ret_empty: got %b want 1", empty_o); else pass_cnt++;
    total_cnt++; if (stk_o !== 12'h000) $display("[TB] FAIL ret_stk_empty: got %h want 000", stk_o); else pass_cnt++;
    pop_i = 1'b0; next_pc_i = 12'hFFF;
    step();
    push_i = 1'b1; next_pc_i = 12'h400;
    step();
    total_cnt++; if (stk_o !== 12'h000) $display("[TB] FAIL call_wrap: got %h want 000", stk_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd1) $display("[TB] FAIL call_wrap_depth: got %0d want 1", depth_o); else pass_cnt++;
    push_i = 1'b0; pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    total_cnt++; if (depth_o !== 5'd0) $display("[TB] FAIL wrap_pop_depth: got %0d want 0", depth_o); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [11:0] want;
    next_pc_i = 12'h000;
    step();
    for (int i = 0; i < 17; i++) begin
      push_i = 1'b1; next_pc_i = 12'(i + 1);
      step();
    end
    push_i = 1'b0;
    total_cnt++; if (full_o !== 1'b1) $display("[TB] FAIL ovf_full: got %b want 1", full_o); else pass_cnt++;
    total_cnt++; if (ovf_o !== 1'b1) $display("[TB] FAIL ovf_flag: got %b want 1", ovf_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd16) $display("[TB] FAIL ovf_depth: got %0d want 16", depth_o); else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      want = 12'(17 - k);
      total_cnt++; if (stk_o !== want) $display("[TB] FAIL ovf_pop_%0d: got %h want %h", k, stk_o, want); else pass_cnt++;
      pop_i = 1'b1;
      step();
    end
    pop_i = 1'b0;
    total_cnt++; if (empty_o !== 1'b1) $display("[TB] FAIL ovf_drained_empty: got %b want 1", empty_o); else pass_cnt++;
    total_cnt++; if (unf_o !== 1'b0) $display("[TB] FAIL ovf_no_unf: got %b want 0", unf_o); else pass_cnt++;
  endtask

  task automatic test_underflow_simul();
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    total_cnt++; if (unf_o !== 1'b1) $display("[TB] FAIL unf_flag: got %b want 1", unf_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd0) $display("[TB] FAIL unf_depth: got %0d want 0", depth_o); else pass_cnt++;
    next_pc_i = 12'h0FF;
    step();
    push_i = 1'b1; next_pc_i = 12'h2FF;
    step();
    push_i = 1'b1; pop_i = 1'b1; next_pc_i = 12'h300;
    step();
    push_i = 1'b0; pop_i = 1'b0;
    total_cnt++; if (stk_o !== 12'h300) $display("[TB] FAIL swap_stk: got %h want 300", stk_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd1) $display("[TB] FAIL swap_depth: got %0d want 1", depth_o); else pass_cnt++;
    rst_i = 1'b1; push_i = 1'b1;
    step();
    rst_i = 1'b0; push_i = 1'b0;
    total_cnt++; if (pc_o !== 12'h000) $display("[TB] FAIL midrst_pc: got %h want 000", pc_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd0) $display("[TB] FAIL midrst_depth: got %0d want 0", depth_o); else pass_cnt++;
    total_cnt++; if ({ovf_o, unf_o} !== 2'b00) $display("[TB] FAIL midrst_flags: got %b want 00", {ovf_o, unf_o}); else pass_cnt++;
    total_cnt++; if (stk_o !== 12'h000) $display("[TB] FAIL midrst_stk: got %h want 000", stk_o); else pass_cnt++;
    push_i = 1'b1; pop_i = 1'b1; next_pc_i = 12'h050;
    step();
    push_i = 1'b0; pop_i = 1'b0;
    total_cnt++; if (depth_o !== 5'd1) $display("[TB] FAIL empty_swap_depth: got %0d want 1", depth_o); else pass_cnt++;
    total_cnt++; if (unf_o !== 1'b1) $display("[TB] FAIL empty_swap_unf: got %b want 1", unf_o); else pass_cnt++;
    total_cnt++; if (stk_o !== 12'h001) $display("[TB] FAIL empty_swap_stk: got %h want 001", stk_o); else pass_cnt++;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

`ifdef PC_STACK_INT_EN
  task automatic test_interrupt();
    next_pc_i = 12'h123;
    step();
    int_ack_i = 1'b1; push_i = 1'b1; zero_i = 1'b1; carry_i = 1'b0; next_pc_i = 12'h008;
    step();
    int_ack_i = 1'b0; push_i = 1'b0; zero_i = 1'b0;
    total_cnt++; if (stk_o !== 12'h123) $display("[TB] FAIL int_stk: got %h want 123", stk_o); else pass_cnt++;
    total_cnt++; if (zero_o !== 1'b1) $display("[TB] FAIL int_zero: got %b want 1", zero_o); else pass_cnt++;
    total_cnt++; if (carry_o !== 1'b0) $display("[TB] FAIL int_carry: got %b want 0", carry_o); else pass_cnt++;
    total_cnt++; if (depth_o !== 5'd1) $display("[TB] FAIL int_depth: got %0d want 1", depth_o); else pass_cnt++;
  endtask
`endif

  initial begin
    rst_i = 1'b1; en_i = 1'b0; next_pc_i = '0; push_i = 1'b0; pop_i = 1'b0;
`ifdef PC_STACK_INT_EN
    int_ack_i = 1'b0; zero_i = 1'b0; carry_i = 1'b0;
`endif
    test_reset();
    test_pc_load_stall();
    test_call_return();
    test_overflow();
    test_underflow_simul();
`ifdef PC_STACK_INT_EN
    test_interrupt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
